// File: rtl/onehot_decoder_seq_if.sv
// Interface for the one-hot decoder: the control/select inputs and the registered
// decode results, with master (driver) and slave (decoder) views.
interface onehot_decoder_seq_if #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4
);
  logic               en;
  logic [1:0]         mode;
  logic [SEL_W-1:0]   sel;
  logic               load;
  logic               step;
  logic [NUM_OUT-1:0] dout;
  logic [SEL_W-1:0]   idx;
  logic               valid;
  logic               wrap;
  logic               err;

  modport master (
    output en, mode, sel, load, step,
    input  dout, idx, valid, wrap, err
  );

  modport slave (
    input  en, mode, sel, load, step,
    output dout, idx, valid, wrap, err
  );
endinterface

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with a scan mode that walks the active
// output up or down on step strobes; optional active-low outputs.
//
// state  | meaning
// IDLE   | outputs inactive; waiting for en=1 with a non-HOLD mode
// ACTIVE | decoding (DIRECT) or scanning (SCAN_UP/SCAN_DOWN), or frozen (HOLD)
module onehot_decoder_seq #(
  parameter int SEL_W      = 2,
  parameter int NUM_OUT    = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_decoder_seq_if.slave  bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [SEL_W:0]     NUM_OUT_EXT = (SEL_W+1)'(NUM_OUT);
  localparam logic [SEL_W-1:0]   LAST_IDX    = SEL_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] INACTIVE    = {NUM_OUT{ACTIVE_LOW != 0}};

  state_t             state;
  logic [NUM_OUT-1:0] dout_q;
  logic [SEL_W-1:0]   idx_q;
  logic               valid_q;
  logic               wrap_q;
  logic               err_q;

  logic               sel_ok;
  logic [SEL_W-1:0]   scan_idx;
  logic               scan_wrap;

  assign sel_ok = {1'b0, bus.sel} < NUM_OUT_EXT;

  // Wrap at NUM_OUT-1 rather than at the natural SEL_W-bit overflow.
  always_comb begin
    scan_idx  = idx_q;
    scan_wrap = 1'b0;
    if (bus.mode == MODE_UP) begin
      if (idx_q == LAST_IDX) begin
        scan_idx  = '0;
        scan_wrap = 1'b1;
      end else begin
        scan_idx = idx_q + 1'b1;
      end
    end else if (bus.mode == MODE_DOWN) begin
      if (idx_q == '0) begin
        scan_idx  = LAST_IDX;
        scan_wrap = 1'b1;
      end else begin
        scan_idx = idx_q - 1'b1;
      end
    end
  end

  function automatic logic [NUM_OUT-1:0] drive(input logic [SEL_W-1:0] i);
    logic [NUM_OUT-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (i == SEL_W'(k)) v[k] = 1'b1;
    end
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dout_q  <= INACTIVE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      if (!bus.en) begin
        state   <= IDLE;
        dout_q  <= INACTIVE;
        valid_q <= 1'b0;
      end else if (bus.mode == MODE_HOLD) begin
        if (state == IDLE) begin
          dout_q  <= INACTIVE;
          valid_q <= 1'b0;
        end
      end else begin
        state <= ACTIVE;
        if (bus.mode == MODE_DIRECT) begin
          if (sel_ok) begin
            dout_q  <= drive(bus.sel);
            idx_q   <= bus.sel;
            valid_q <= 1'b1;
          end else begin
            dout_q  <= INACTIVE;
            valid_q <= 1'b0;
            err_q   <= 1'b1;
          end
        end else if (bus.load) begin
          if (sel_ok) begin
            idx_q  <= bus.sel;
            dout_q <= drive(bus.sel);
          end else begin
            dout_q <= drive(idx_q);
            err_q  <= 1'b1;
          end
          valid_q <= 1'b1;
        end else if (bus.step && state == ACTIVE) begin
          // The entry cycle from IDLE only presents the retained index.
          idx_q   <= scan_idx;
          dout_q  <= drive(scan_idx);
          valid_q <= 1'b1;
          wrap_q  <= scan_wrap;
        end else begin
          dout_q  <= drive(idx_q);
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.dout  = dout_q;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: three instances cover the default
// 2/4 decoder, a 3-bit/5-output scanner and an active-low variant.
module tb_onehot_decoder_seq;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  onehot_decoder_seq_if #(.SEL_W(2), .NUM_OUT(4)) a_if ();
  onehot_decoder_seq_if #(.SEL_W(3), .NUM_OUT(5)) b_if ();
  onehot_decoder_seq_if #(.SEL_W(2), .NUM_OUT(4)) c_if ();

  onehot_decoder_seq #(.SEL_W(2), .NUM_OUT(4), .ACTIVE_LOW(0)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  onehot_decoder_seq #(.SEL_W(3), .NUM_OUT(5), .ACTIVE_LOW(0)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  onehot_decoder_seq #(.SEL_W(2), .NUM_OUT(4), .ACTIVE_LOW(1)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {dout, idx, valid, wrap, err} snapshots
  logic [8:0]  a_obs;
  logic [10:0] b_obs;
  logic [8:0]  c_obs;
  assign a_obs = {a_if.dout, a_if.idx, a_if.valid, a_if.wrap, a_if.err};
  assign b_obs = {b_if.dout, b_if.idx, b_if.valid, b_if.wrap, b_if.err};
  assign c_obs = {c_if.dout, c_if.idx, c_if.valid, c_if.wrap, c_if.err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (a_obs !== {4'b0000, 2'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_a: got %b want %b", a_obs, {4'b0000, 2'd0, 3'b000});
    end
    n_checks++;
    if (b_obs !== {5'b00000, 3'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_b: got %b want %b", b_obs, {5'b00000, 3'd0, 3'b000});
    end
    n_checks++;
    if (c_obs !== {4'b1111, 2'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_c: got %b want %b", c_obs, {4'b1111, 2'd0, 3'b000});
    end
    rst = 1'b0;
  endtask

  task automatic test_direct();
    logic [3:0] exp_d [4];
    exp_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    a_if.en = 1'b1; a_if.mode = 2'b00;
    for (int s = 0; s < 4; s++) begin
      a_if.sel = 2'(s);
      tick();
      n_checks++;
      if (a_obs !== {exp_d[s], 2'(s), 3'b100}) begin
        n_fail++; $display("FAIL direct_sel%0d: got %b want %b", s, a_obs, {exp_d[s], 2'(s), 3'b100});
      end
    end
  endtask

  task automatic test_back_to_back();
    a_if.mode = 2'b01; a_if.step = 1'b1;
    tick();
    n_checks++;
    if (a_obs !== {4'b0001, 2'd0, 3'b110}) begin
      n_fail++; $display("FAIL natural_wrap: got %b want %b", a_obs, {4'b0001, 2'd0, 3'b110});
    end
    a_if.step = 1'b0; a_if.mode = 2'b00; a_if.sel = 2'd2;
    tick();
    n_checks++;
    if (a_obs !== {4'b0100, 2'd2, 3'b100}) begin
      n_fail++; $display("FAIL scan_to_direct: got %b want %b", a_obs, {4'b0100, 2'd2, 3'b100});
    end
    a_if.mode = 2'b10; a_if.step = 1'b1;
    tick();
    n_checks++;
    if (a_obs !== {4'b0010, 2'd1, 3'b100}) begin
      n_fail++; $display("FAIL direct_to_scan: got %b want %b", a_obs, {4'b0010, 2'd1, 3'b100});
    end
    a_if.step = 1'b0; a_if.en = 1'b0;
    tick();
    n_checks++;
    if (a_obs !== {4'b0000, 2'd1, 3'b000}) begin
      n_fail++; $display("FAIL disable_a: got %b want %b", a_obs, {4'b0000, 2'd1, 3'b000});
    end
  endtask

  task automatic test_direct_err();
    b_if.en = 1'b1; b_if.mode = 2'b00; b_if.sel = 3'd2;
    tick();
    n_checks++;
    if (b_obs !== {5'b00100, 3'd2, 3'b100}) begin
      n_fail++; $display("FAIL direct_b_sel2: got %b want %b", b_obs, {5'b00100, 3'd2, 3'b100});
    end
    b_if.sel = 3'd6;
    tick();
    n_checks++;
    if (b_obs !== {5'b00000, 3'd2, 3'b001}) begin
      n_fail++; $display("FAIL direct_err: got %b want %b", b_obs, {5'b00000, 3'd2, 3'b001});
    end
    b_if.sel = 3'd1;
    tick();
    n_checks++;
    if (b_obs !== {5'b00010, 3'd1, 3'b100}) begin
      n_fail++; $display("FAIL err_clears: got %b want %b", b_obs, {5'b00010, 3'd1, 3'b100});
    end
  endtask

  task automatic test_scan_up();
    logic [10:0] exp_v [4];
    exp_v = '{{5'b10000, 3'd4, 3'b100}, {5'b00001, 3'd0, 3'b110},
              {5'b00010, 3'd1, 3'b100}, {5'b00010, 3'd1, 3'b100}};
    b_if.mode = 2'b01; b_if.load = 1'b1; b_if.sel = 3'd3;
    tick();
    n_checks++;
    if (b_obs !== {5'b01000, 3'd3, 3'b100}) begin
      n_fail++; $display("FAIL scan_load3: got %b want %b", b_obs, {5'b01000, 3'd3, 3'b100});
    end
    b_if.load = 1'b0; b_if.step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) b_if.step = 1'b0;
      tick();
      n_checks++;
      if (b_obs !== exp_v[i]) begin
        n_fail++; $display("FAIL scan_up_%0d: got %b want %b", i, b_obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_scan_down();
    b_if.mode = 2'b10; b_if.load = 1'b1; b_if.sel = 3'd0;
    tick();
    b_if.load = 1'b0; b_if.step = 1'b1;
    tick();
    n_checks++;
    if (b_obs !== {5'b10000, 3'd4, 3'b110}) begin
      n_fail++; $display("FAIL scan_down_wrap: got %b want %b", b_obs, {5'b10000, 3'd4, 3'b110});
    end
    b_if.step = 1'b0;
  endtask

  task automatic test_load_step();
    b_if.mode = 2'b01; b_if.load = 1'b1; b_if.step = 1'b1; b_if.sel = 3'd2;
    tick();
    n_checks++;
    if (b_obs !== {5'b00100, 3'd2, 3'b100}) begin
      n_fail++; $display("FAIL load_beats_step: got %b want %b", b_obs, {5'b00100, 3'd2, 3'b100});
    end
    b_if.load = 1'b0;
    tick();
    n_checks++;
    if (b_obs !== {5'b01000, 3'd3, 3'b100}) begin
      n_fail++; $display("FAIL step_after_load: got %b want %b", b_obs, {5'b01000, 3'd3, 3'b100});
    end
    b_if.step = 1'b0;
    b_if.load = 1'b1; b_if.sel = 3'd7;
    tick();
    n_checks++;
    if (b_obs !== {5'b01000, 3'd3, 3'b101}) begin
      n_fail++; $display("FAIL load_err: got %b want %b", b_obs, {5'b01000, 3'd3, 3'b101});
    end
    b_if.load = 1'b0;
  endtask

  task automatic test_hold_disable();
    b_if.mode = 2'b11; b_if.step = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (b_obs !== {5'b01000, 3'd3, 3'b100}) begin
        n_fail++; $display("FAIL hold_%0d: got %b want %b", i, b_obs, {5'b01000, 3'd3, 3'b100});
      end
    end
    b_if.en = 1'b0; b_if.mode = 2'b01;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (b_obs !== {5'b00000, 3'd3, 3'b000}) begin
        n_fail++; $display("FAIL disable_%0d: got %b want %b", i, b_obs, {5'b00000, 3'd3, 3'b000});
      end
    end
    b_if.en = 1'b1;
    tick();
    n_checks++;
    if (b_obs !== {5'b01000, 3'd3, 3'b100}) begin
      n_fail++; $display("FAIL entry_no_step: got %b want %b", b_obs, {5'b01000, 3'd3, 3'b100});
    end
    tick();
    n_checks++;
    if (b_obs !== {5'b10000, 3'd4, 3'b100}) begin
      n_fail++; $display("FAIL step_after_entry: got %b want %b", b_obs, {5'b10000, 3'd4, 3'b100});
    end
    b_if.step = 1'b0; b_if.en = 1'b0;
    tick();
    b_if.en = 1'b1; b_if.mode = 2'b11;
    tick();
    n_checks++;
    if (b_obs !== {5'b00000, 3'd4, 3'b000}) begin
      n_fail++; $display("FAIL idle_hold: got %b want %b", b_obs, {5'b00000, 3'd4, 3'b000});
    end
    b_if.en = 1'b0;
  endtask

  task automatic test_active_low();
    c_if.en = 1'b1; c_if.mode = 2'b00; c_if.sel = 2'd1;
    tick();
    n_checks++;
    if (c_obs !== {4'b1101, 2'd1, 3'b100}) begin
      n_fail++; $display("FAIL active_low_direct: got %b want %b", c_obs, {4'b1101, 2'd1, 3'b100});
    end
  endtask

  task automatic test_reset_mid_scan();
    c_if.mode = 2'b01; c_if.load = 1'b1; c_if.sel = 2'd3;
    tick();
    n_checks++;
    if (c_obs !== {4'b0111, 2'd3, 3'b100}) begin
      n_fail++; $display("FAIL low_load3: got %b want %b", c_obs, {4'b0111, 2'd3, 3'b100});
    end
    c_if.load = 1'b0; c_if.step = 1'b1; rst = 1'b1;
    tick();
    n_checks++;
    if (c_obs !== {4'b1111, 2'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_mid_scan: got %b want %b", c_obs, {4'b1111, 2'd0, 3'b000});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (c_obs !== {4'b1110, 2'd0, 3'b100}) begin
      n_fail++; $display("FAIL entry_after_reset: got %b want %b", c_obs, {4'b1110, 2'd0, 3'b100});
    end
    tick();
    n_checks++;
    if (c_obs !== {4'b1101, 2'd1, 3'b100}) begin
      n_fail++; $display("FAIL low_step: got %b want %b", c_obs, {4'b1101, 2'd1, 3'b100});
    end
    c_if.step = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    a_if.en = 1'b0; a_if.mode = 2'b00; a_if.sel = '0; a_if.load = 1'b0; a_if.step = 1'b0;
    b_if.en = 1'b0; b_if.mode = 2'b00; b_if.sel = '0; b_if.load = 1'b0; b_if.step = 1'b0;
    c_if.en = 1'b0; c_if.mode = 2'b00; c_if.sel = '0; c_if.load = 1'b0; c_if.step = 1'b0;
    test_reset();
    test_direct();
    test_back_to_back();
    test_direct_err();
    test_scan_up();
    test_scan_down();
    test_load_step();
    test_hold_disable();
    test_active_low();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
Parametrised, registered binary-to-one-hot decoder. It generalises the 2-to-4 decoder to SEL_W select bits and NUM_OUT outputs, with optional active-low outputs. It adds a scan mode, in which an internal index walks the one-hot output up or down on step strobes. Used for row/channel enables, LED/segment scanning and bank selects.

Parameters:
SEL_W, 2, select width in bits (legal range 1..8).
NUM_OUT, 4, number of outputs; must satisfy 2 <= NUM_OUT <= 2**SEL_W.
ACTIVE_LOW, 0, when 1, all dout bits are inverted (active bit 0, inactive bits 1).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  block enable.
mode  in  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
sel  in  SEL_W  binary select in DIRECT mode; load value in scan modes.
load  in  1  scan modes only: load sel into the index.
step  in  1  scan modes only: advance the index by one.
dout  out  NUM_OUT  registered one-hot (or one-cold) output.
idx  out  SEL_W  registered binary index of the active output.
valid  out  1  dout currently drives an active bit.
wrap  out  1  one-cycle pulse when the scan index wraps.
err  out  1  one-cycle pulse when sel >= NUM_OUT is presented for decode or load.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; rst has priority over all other inputs.
- Reset values: dout all inactive (all 0, or all 1 if ACTIVE_LOW), idx=0, valid=0, wrap=0, err=0; state=IDLE.
- "Inactive" and "one-hot" below are before the ACTIVE_LOW inversion, which is applied at the output register.
- States: IDLE and ACTIVE.
  - IDLE -> ACTIVE on the first cycle with en=1 and mode != HOLD.
  - ACTIVE -> IDLE when en=0.
  - HOLD while in IDLE stays in IDLE with outputs inactive.
- en=0: next cycle dout inactive and valid=0; idx and the internal index are held; wrap=0 and err=0.
- DIRECT mode (en=1), latency 1 cycle:
  - If sel < NUM_OUT: dout=onehot(sel), idx=sel, valid=1.
  - If sel >= NUM_OUT: dout inactive, valid=0, idx held, err=1 for one cycle.
  - load and step are ignored.
- SCAN_UP / SCAN_DOWN (en=1):
  - Priority order: load, then step.
  - load with sel < NUM_OUT: idx=sel. load with sel >= NUM_OUT: err pulse, idx held.
  - load and step in the same cycle: the load is applied and the step is dropped.
  - step, SCAN_UP: idx+1; at NUM_OUT-1 it wraps to 0 with a wrap pulse.
  - step, SCAN_DOWN: idx-1; at 0 it wraps to NUM_OUT-1 with a wrap pulse.
  - The IDLE->ACTIVE entry cycle presents onehot(idx) without stepping. load is honoured on that cycle; step is ignored.
  - dout=onehot(new idx) and valid=1, both 1 cycle after the causing input.
  - With no load or step, outputs hold.
- HOLD (ACTIVE): dout, idx and valid frozen; wrap=0, err=0; load and step ignored.
- Mode switch: the index is shared across modes. DIRECT -> SCAN continues from the last decoded idx; SCAN -> DIRECT takes sel on the next cycle.
- Arithmetic: the index is SEL_W bits and is compared against NUM_OUT. When NUM_OUT < 2**SEL_W, wrap happens at NUM_OUT-1, not at the natural overflow.
- Invariants:
  - When valid=1, exactly one dout bit is active.
  - When valid=0, all dout bits are inactive.
  - wrap and err never assert while en=0 or in reset.
- Reset mid-scan: next cycle returns to reset values; a step or load in the reset cycle is lost.

Test Plan:
- Reset, then en=1, DIRECT, sel=0..3 on successive cycles (defaults) -> dout 0001, 0010, 0100, 1000, each one cycle after sel; idx tracks sel; valid=1 from the cycle after en.
- NUM_OUT=5, SEL_W=3, DIRECT, sel=6 -> dout 00000, valid=0, err=1 for one cycle, idx unchanged.
- SCAN_UP, NUM_OUT=5, SEL_W=3: load sel=3, then 3 steps -> idx 3,4,0,1; wrap pulses only on 4->0. SCAN_DOWN from 0 with one step -> idx 4, wrap=1.
- load=1 and step=1 in the same cycle with sel=2 -> idx=2 (no step applied); next step -> 3.
- HOLD with step pulses -> outputs unchanged. en=0 -> dout 0, valid=0. en=1 again in SCAN_UP -> onehot of the retained idx, no step on the entry cycle.
- ACTIVE_LOW=1, DIRECT, sel=1 -> dout 1101. rst asserted mid-scan at idx=3 -> next cycle dout 1111, idx=0, valid=0.
